regx_bank: RTL and testbench

REGX_BANK -- requirements
Module: regx_bank

---
 rtl/regx_bank.sv | 105 ++++++++++
 tb/tb_regx_bank.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/regx_bank.sv
// regx_bank: keyed, write-protected 8-bit register bank with relock timeout and sticky status.
// Define REGX_BANK_SHADOW_EN to stage protected writes in shadows committed by upd.
module regx_bank #(
   parameter int         N_REG     = 16,
   parameter int         AW        = 6,
   parameter int         LOCK_BASE = 8,
   parameter logic [7:0] KEY0      = 8'h5a,
   parameter logic [7:0] KEY1      = 8'ha5,
   parameter int         TMO       = 255,
   parameter logic [7:0] UNREGX_D  = 8'hff
) (
   input  logic             clk,
   input  logic             rrst,
   input  logic             regx_r,
   input  logic             regx_w,
   input  logic [AW-1:0]    regx_addr,
   input  logic [7:0]       regx_wdat,
   output logic [7:0]       regx_rdat,
   output logic [N_REG*8-1:0] r_bank,
   input  logic             upd,
   input  logic [6:0]       sts_in,
   output logic             unlocked,
   output logic             err_wp
);
   typedef enum logic [1:0] {LOCK = 2'd0, KEY1W = 2'd1, UNLK = 2'd2} state_t;
   localparam logic [AW-1:0] A_KEY = AW'(N_REG);
   localparam logic [AW-1:0] A_STS = AW'(N_REG + 1);
   localparam logic [AW-1:0] A_LB  = AW'(LOCK_BASE);
   localparam logic [7:0]    TMO8  = 8'(TMO);
   state_t state, nxt;
   logic [7:0] cnt, nxt_cnt, sts, rd_val;
   logic [N_REG-1:0][7:0] bank;
   logic prot, viol, acc, wr_key, wr_sts;
   assign prot     = regx_addr >= A_LB && regx_addr < A_KEY;
   assign wr_key   = regx_w && regx_addr == A_KEY;
   assign wr_sts   = regx_w && regx_addr == A_STS;
   assign acc      = regx_w && prot && state == UNLK;
   assign viol     = regx_w && prot && state != UNLK;
   assign unlocked = state == UNLK;
   assign r_bank   = bank;
   always_ff @(posedge clk)
      if (rrst) begin
         state <= LOCK;
         cnt   <= '0;
      end else begin
         state <= nxt;
         cnt   <= nxt_cnt;
      end
   // counter is only meaningful in UNLK; reloaded on entry and on every accepted protected write
   always_comb begin
      nxt = state;
      unique case (state)
         LOCK:    nxt = (wr_key && regx_wdat == KEY0) ? KEY1W : LOCK;
         KEY1W:   nxt = !regx_w ? KEY1W : (wr_key && regx_wdat == KEY1) ? UNLK : LOCK;
         UNLK:    nxt = (wr_key || cnt == 8'd0) ? LOCK : UNLK;
         default: nxt = LOCK;
      endcase
      nxt_cnt = nxt != UNLK ? 8'd0 : (state != UNLK || acc) ? TMO8 : cnt - 8'd1;
   end
   always_comb begin
      rd_val = regx_addr == A_KEY ? {6'h0, state} : regx_addr == A_STS ? sts : UNREGX_D;
      for (int j = 0; j < N_REG; j++)
         if (regx_addr == AW'(j)) rd_val = bank[j];
   end
   always_ff @(posedge clk)
      if (rrst) begin
         sts       <= '0;
         err_wp    <= 1'b0;
         regx_rdat <= '0;
      end else begin
         sts    <= (sts & ~(wr_sts ? regx_wdat : 8'h00)) | {sts_in, viol};
         err_wp <= viol;
         if (regx_r) regx_rdat <= rd_val;
      end
   genvar i;
   for (i = 0; i < N_REG; i++) begin : g_reg
      localparam logic [AW-1:0] IA = AW'(i);
      if (i < LOCK_BASE) begin : g_open
         always_ff @(posedge clk)
            if (rrst) bank[i] <= '0;
            else if (regx_w && regx_addr == IA) bank[i] <= regx_wdat;
      end else begin : g_prot
`ifdef REGX_BANK_SHADOW_EN
         logic [7:0] shadow;
         // commit uses the pre-write shadow; a same-cycle write waits for the next upd
         always_ff @(posedge clk)
            if (rrst) begin
               shadow  <= '0;
               bank[i] <= '0;
            end else begin
               if (acc && regx_addr == IA) shadow <= regx_wdat;
               if (upd) bank[i] <= shadow;
            end
`else
         always_ff @(posedge clk)
            if (rrst) bank[i] <= '0;
            else if (acc && regx_addr == IA) bank[i] <= regx_wdat;
`endif
      end
   end
`ifndef REGX_BANK_SHADOW_EN
   logic unused_upd;
   assign unused_upd = upd;
`endif
endmodule

// File: tb/tb_regx_bank.sv
// tb_regx_bank: directed literal checks plus randomized traffic against a cycle-level behavioural model.
module tb_regx_bank;
   localparam int NR = 16, LB = 8, TM = 4, AK = NR, AS = NR + 1;
   logic clk = 1'b0, rrst = 1'b1, regx_r = 1'b0, regx_w = 1'b0, upd = 1'b0;
   logic [5:0] regx_addr = '0;
   logic [7:0] regx_wdat = '0, regx_rdat;
   logic [6:0] sts_in = '0;
   logic [NR*8-1:0] r_bank;
   logic unlocked, err_wp;
   int checks = 0, errors = 0;
   bit chk_en = 1'b0;
   logic [7:0] m_bank [NR];
   logic [7:0] m_shd [NR];
   logic [7:0] m_sts = '0, m_rdat = '0;
   bit m_err = 1'b0;
   int m_st = 0, m_left = 0;

   regx_bank #(.N_REG(NR), .AW(6), .LOCK_BASE(LB), .TMO(TM)) dut (
      .clk(clk), .rrst(rrst), .regx_r(regx_r), .regx_w(regx_w), .regx_addr(regx_addr),
      .regx_wdat(regx_wdat), .regx_rdat(regx_rdat), .r_bank(r_bank), .upd(upd),
      .sts_in(sts_in), .unlocked(unlocked), .err_wp(err_wp));

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", n, act, exp);
      end
   endtask

   function automatic logic [NR*8-1:0] m_packed();
      logic [NR*8-1:0] v;
      for (int k = 0; k < NR; k++) v[8*k +: 8] = m_bank[k];
      return v;
   endfunction

   // unlock window: TMO+1 cycles after entry or after the last accepted protected write
   always @(posedge clk) begin : model
      int a;
      bit prot, acc, kw;
      logic [7:0] rv, clr;
      a = int'(regx_addr);
      if (rrst) begin
         for (int k = 0; k < NR; k++) begin m_bank[k] = '0; m_shd[k] = '0; end
         m_sts = '0; m_rdat = '0; m_err = 1'b0; m_st = 0; m_left = 0;
      end else begin
         rv = a < NR ? m_bank[a] : a == AK ? 8'(m_st) : a == AS ? m_sts : 8'hff;
         if (regx_r) m_rdat = rv;
         prot = a >= LB && a < NR;
         acc = regx_w && prot && m_st == 2;
         m_err = regx_w && prot && m_st != 2;
         clr = (regx_w && a == AS) ? regx_wdat : 8'h00;
         m_sts = (m_sts & ~clr) | {sts_in, m_err};
         if (regx_w && a < LB) m_bank[a] = regx_wdat;
`ifdef REGX_BANK_SHADOW_EN
         if (upd) for (int k = LB; k < NR; k++) m_bank[k] = m_shd[k];
         if (acc) m_shd[a] = regx_wdat;
`else
         if (acc) m_bank[a] = regx_wdat;
`endif
         kw = regx_w && a == AK;
         if (m_st == 0) begin
            if (kw && regx_wdat == 8'h5a) m_st = 1;
         end else if (m_st == 1) begin
            if (regx_w) begin
               if (kw && regx_wdat == 8'ha5) begin m_st = 2; m_left = TM + 1; end
               else m_st = 0;
            end
         end else begin
            if (kw || m_left == 1) m_st = 0;
            else m_left = acc ? TM + 1 : m_left - 1;
         end
      end
   end

   always @(negedge clk)
      if (chk_en) begin
         chk("rdat", regx_rdat, m_rdat);
         chk("r_bank", r_bank, m_packed());
         chk("unlocked", unlocked, m_st == 2);
         chk("err_wp", err_wp, m_err);
      end

   task automatic cyc(input bit r, input bit w, input int a = 0, input logic [7:0] d = 8'h00,
                      input bit u = 1'b0, input logic [6:0] s = 7'h0);
      regx_r = r; regx_w = w; regx_addr = 6'(a); regx_wdat = d; upd = u; sts_in = s;
      @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_bank", r_bank, '0);
      chk("rst_rdat", regx_rdat, 8'h00);
      chk("rst_unlocked", unlocked, 1'b0);
      chk("rst_err", err_wp, 1'b0);
      rrst = 1'b0;
      chk_en = 1'b1;
      cyc(0, 1, 2, 8'h3c);
      chk("wr_idx2", r_bank[23:16], 8'h3c);
      cyc(1, 0, 2);
      chk("rd_idx2", regx_rdat, 8'h3c);
      cyc(0, 1, 9, 8'h77);
      chk("wp_pulse", err_wp, 1'b1);
      cyc(0, 0);
      chk("wp_pulse_end", err_wp, 1'b0);
      chk("wp_bank9", r_bank[79:72], 8'h00);
      cyc(1, 0, AS);
      chk("sts_wp", regx_rdat, 8'h01);
      cyc(0, 1, AS, 8'h01);
      cyc(1, 0, AS);
      chk("sts_w1c", regx_rdat, 8'h00);
      cyc(0, 1, AK, 8'h5a);
      cyc(0, 1, AK, 8'ha5);
      cyc(1, 0, AK);
      chk("key_unlk", regx_rdat, 8'h02);
      cyc(0, 1, 8, 8'h99);
`ifdef REGX_BANK_SHADOW_EN
      chk("shadow_hold", r_bank[71:64], 8'h00);
`else
      chk("direct_wr", r_bank[71:64], 8'h99);
`endif
      cyc(0, 0, 0, 8'h00, 1'b1);
      chk("commit", r_bank[71:64], 8'h99);
      cyc(0, 1, AK, 8'h00);
      cyc(1, 0, AK);
      chk("relock", regx_rdat, 8'h00);
      cyc(0, 1, AK, 8'h5a);
      cyc(1, 0, AK);
      chk("key1w", regx_rdat, 8'h01);
      cyc(0, 1, 0, 8'h11);
      cyc(1, 0, AK);
      chk("abort_seq", regx_rdat, 8'h00);
      cyc(0, 1, AK, 8'ha5);
      cyc(1, 0, AK);
      chk("no_unlock", regx_rdat, 8'h00);
      cyc(0, 1, AK, 8'h5a);
      cyc(0, 1, AK, 8'ha5);
      chk("tmo_entry", unlocked, 1'b1);
      for (int k = 0; k < 4; k++) begin cyc(0, 0); chk("tmo_hold", unlocked, 1'b1); end
      cyc(0, 0);
      chk("tmo_drop", unlocked, 1'b0);
      cyc(0, 1, AK, 8'h5a);
      cyc(0, 1, AK, 8'ha5);
      cyc(0, 0);
      cyc(0, 0);
      cyc(0, 1, 8, 8'h42);
      for (int k = 0; k < 4; k++) begin cyc(0, 0); chk("tmo_ext_hold", unlocked, 1'b1); end
      cyc(0, 0);
      chk("tmo_ext_drop", unlocked, 1'b0);
      cyc(0, 1, AS, 8'h08, 1'b0, 7'b0000100);
      cyc(1, 0, AS);
      chk("sts_set_wins", regx_rdat, 8'h08);
      cyc(0, 1, AS, 8'h08);
      cyc(1, 0, AS);
      chk("sts_clear", regx_rdat, 8'h00);
      cyc(0, 1, AK, 8'h5a);
      cyc(0, 1, AK, 8'ha5);
      cyc(0, 1, 9, 8'h55);
      rrst = 1'b1;
      cyc(0, 0);
      rrst = 1'b0;
      cyc(0, 0, 0, 8'h00, 1'b1);
      chk("rst_drop_shadow", r_bank[79:72], 8'h00);
      chk("rst_locked", unlocked, 1'b0);
      for (int n = 0; n < 3000; n++) begin
         int p, a;
         logic [7:0] d;
         if ($urandom_range(0, 29) == 0) begin
            cyc(0, 1, AK, 8'h5a);
            cyc(0, 1, AK, 8'ha5);
         end
         p = int'($urandom_range(0, 99));
         a = p < 25 ? AK : p < 35 ? AS : p < 95 ? int'($urandom_range(0, 15)) : int'($urandom_range(18, 63));
         p = int'($urandom_range(0, 5));
         d = p == 0 ? 8'h5a : p == 1 ? 8'ha5 : 8'($urandom);
         rrst = $urandom_range(0, 299) == 0;
         cyc($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, a, d, $urandom_range(0, 7) == 0,
             $urandom_range(0, 9) == 0 ? 7'($urandom) : 7'h0);
         rrst = 1'b0;
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
